mips_seq_ctrl: RTL and testbench
================================

Name: mips_seq_ctrl

Overview:
Multi-cycle sequencer for the custom 32-bit MIPS-style core. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the PC, IR, register-file write and memory handshakes. Its control inputs are the instruction decoder's outputs, taken from the held IR: reg_Write, mux_D, branch_Select, polarity_Select and mem_Write. It gates those signals into single-cycle enables and resolves branches from the ALU zero flag.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory request (imem or dmem) may wait for ack before FAULT; must be >= 2
CNT_W, 32, width of performance counters (feature only)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  level; 1 = keep issuing instructions
imem_ack  in  1  instruction memory ack; IR data valid this cycle
dmem_ack  in  1  data memory ack; read data valid / write accepted
reg_Write  in  1  decoder: instruction writes register file
mux_D  in  2  decoder: 0 ALU, 1 memory load, 2 alternate result
branch_Select  in  2  decoder: 0 none, 1 conditional, 2 jump-register, 3 jump
polarity_Select  in  1  decoder: inverts branch condition
mem_Write  in  1  decoder: store
zero_flag  in  1  ALU zero result, valid in EXEC
imem_req  out  1  fetch request
ir_load  out  1  latch IR
dmem_req  out  1  data request
dmem_we  out  1  data write strobe (qualifies dmem_req)
rf_we  out  1  register-file write enable
pc_en  out  1  PC update strobe
pc_src  out  2  0 PC+1, 1 branch target, 2 reg A, 3 jump target
busy  out  1  not IDLE/FAULT
fault  out  1  memory timeout, sticky
state_o  out  3  current state encoding

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=7.
- Reset (async, rst_n=0): state IDLE; every output 0; timeout counter, taken latch and pc_src latch all 0. Reset mid-request drops imem_req/dmem_req immediately.
- IDLE: outputs 0. run=1 -> FETCH.
- FETCH: imem_req=1. A cycle with imem_ack=1 asserts ir_load that cycle and goes to DECODE.
- DECODE: one cycle for register read / decoder settle -> EXEC.
- EXEC branch resolution:
  - taken = (branch_Select==1) ? (zero_flag ^ polarity_Select) : (branch_Select!=0).
  - latch psrc = taken ? branch_Select : 0.
- EXEC next state:
  - mem_Write=1 or mux_D==1 -> MEM.
  - else reg_Write=1 -> WB.
  - else final: pc_en=1, pc_src=psrc.
- MEM: dmem_req=1, dmem_we=mem_Write.
  - On dmem_ack with load (mux_D==1) -> WB.
  - On dmem_ack otherwise: final, pc_en=1, pc_src=psrc.
- WB: rf_we=reg_Write, pc_en=1, pc_src=psrc; final.
- Final state: next state is FETCH if run=1, else IDLE. run is only sampled at instruction boundaries; an instruction in flight always completes.
- pc_en pulses exactly once per instruction. rf_we pulses at most once. pc_src is 0 whenever pc_en=0.
- Latency with zero-wait ack: ALU op 4 cycles (FETCH, DECODE, EXEC, WB), store 4, load 5, non-link branch 3.
- Timeout: counter clears on entering FETCH/MEM and increments each cycle without ack.
  - Reaching MEM_TIMEOUT-1 with no ack -> FAULT next cycle.
  - Ack arriving on the limit cycle wins over timeout.
- FAULT: fault=1, all other outputs 0, busy=0; exit only via rst_n.
- Decoder inputs are stable from DECODE to instruction end (IR held); the block does not re-register them.
- NOP (all decoder outputs 0): FETCH, DECODE, EXEC-final.

Optional Feature:
MIPS_SEQ_PERF_CNT_EN:
- Defined: adds outputs retired_cnt[CNT_W-1:0] (+1 per pc_en) and stall_cnt[CNT_W-1:0] (+1 per FETCH/MEM cycle without ack). Both wrap at 2^CNT_W, reset to 0, and hold in FAULT.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package mips_seq_pkg holds:
  - state encodings;
  - PC_SRC_* codes;
  - BR_NONE/BR_COND/BR_JR/BR_J;
  - MUXD_ALU/MUXD_MEM/MUXD_ALT.
- One sub-module, seq_timeout_timer (clear, tick, ack, expired), shared by FETCH and MEM waits.

Test Plan:
- ALU op (reg_Write=1, branch_Select=0), imem_ack in first FETCH cycle -> ir_load in cycle 1; rf_we=1, pc_en=1, pc_src=0 in cycle 4; FETCH again in cycle 5.
- Load (mux_D=1, reg_Write=1), dmem_ack after 3 wait cycles -> dmem_req high 4 cycles with dmem_we=0; rf_we one cycle after ack.
- Store (mem_Write=1) -> dmem_we=1 with dmem_req; pc_en on the ack cycle; rf_we never asserted.
- branch_Select=1: polarity 0 with zero_flag=1 -> pc_src=1; polarity 1 with zero_flag=1 -> pc_src=0. Both complete in 3 cycles.
- Jump-and-link (branch_Select=3, reg_Write=1) -> WB with rf_we=1, pc_en=1, pc_src=3; run dropped during EXEC -> IDLE after WB.
- imem_ack held 0 with MEM_TIMEOUT=16 -> fault=1 after 16 FETCH cycles, imem_req=0 and stays FAULT. rst_n pulse -> IDLE, fault=0. rst_n low mid-MEM -> dmem_req=0 immediately.

Source files
------------

// File: rtl/mips_seq_pkg.sv
// mips_seq_pkg: shared definitions for the multi-cycle sequencer.
//   - seq_state_e : sequencer state encodings (also visible on state_o)
//   - PC_SRC_*    : PC source select codes driven on pc_src
//   - BR_*        : decoder branch_Select codes
//   - MUXD_*      : decoder mux_D (result source) codes
//   - moore_t / moore_of : per-state registered output bundle
//   - branch_psrc / is_load : small decode helpers
package mips_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd7
  } seq_state_e;

  localparam logic [1:0] PC_SRC_SEQ = 2'd0;  // PC + 1
  localparam logic [1:0] PC_SRC_BR  = 2'd1;  // branch target
  localparam logic [1:0] PC_SRC_REG = 2'd2;  // register A
  localparam logic [1:0] PC_SRC_JMP = 2'd3;  // jump target

  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_COND = 2'd1;
  localparam logic [1:0] BR_JR   = 2'd2;
  localparam logic [1:0] BR_J    = 2'd3;

  localparam logic [1:0] MUXD_ALU = 2'd0;
  localparam logic [1:0] MUXD_MEM = 2'd1;
  localparam logic [1:0] MUXD_ALT = 2'd2;

  // Outputs that depend only on the state being entered (plus decoder
  // fields that are already stable by then), so they can be registered.
  typedef struct packed {
    logic imem_req;
    logic dmem_req;
    logic dmem_we;
    logic rf_we;
    logic pc_en_wb;
    logic busy;
    logic fault;
  } moore_t;

  function automatic moore_t moore_of(seq_state_e s, logic mem_write, logic reg_write);
    moore_t m;
    m = '0;
    case (s)
      S_IDLE:   m = '0;
      S_FETCH:  begin m.imem_req = 1'b1; m.busy = 1'b1; end
      S_DECODE: m.busy = 1'b1;
      S_EXEC:   m.busy = 1'b1;
      S_MEM:    begin m.dmem_req = 1'b1; m.dmem_we = mem_write; m.busy = 1'b1; end
      S_WB:     begin m.rf_we = reg_write; m.pc_en_wb = 1'b1; m.busy = 1'b1; end
      S_FAULT:  m.fault = 1'b1;
      default:  m.fault = 1'b1;
    endcase
    return m;
  endfunction

  // PC source for this instruction: the branch code itself when taken,
  // sequential otherwise. Conditional branches use zero ^ polarity.
  function automatic logic [1:0] branch_psrc(logic [1:0] bsel, logic zero, logic pol);
    logic [1:0] p;
    case (bsel)
      BR_NONE: p = PC_SRC_SEQ;
      BR_COND: p = (zero ^ pol) ? PC_SRC_BR : PC_SRC_SEQ;
      BR_JR:   p = PC_SRC_REG;
      BR_J:    p = PC_SRC_JMP;
      default: p = PC_SRC_SEQ;
    endcase
    return p;
  endfunction

  function automatic logic is_load(logic [1:0] muxd);
    logic r;
    case (muxd)
      MUXD_ALU: r = 1'b0;
      MUXD_MEM: r = 1'b1;
      MUXD_ALT: r = 1'b0;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mips_seq_ctrl_timer.sv
// seq_timeout_timer: wait-cycle counter shared by the FETCH and MEM waits.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clear      : hold the count at zero (asserted outside a wait state)
//   tick       : currently waiting on a memory ack
//   ack        : the awaited ack arrived this cycle (restarts the count)
//   expired    : this is the last permitted wait cycle and no ack came
module seq_timeout_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  input  logic ack,
  output logic expired
);

  localparam int CW = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] cnt_r;

  // Count un-acked wait cycles; any ack or leaving the wait restarts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clear || ack) begin
      cnt_r <= '0;
    end else if (tick) begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // An ack on the limit cycle wins, hence the ~ack term.
  assign expired = tick & ~ack & (cnt_r == LIMIT);

endmodule

// File: rtl/mips_seq_ctrl.sv
// mips_seq_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer.
// Optional feature macro: MIPS_SEQ_PERF_CNT_EN (adds retired_cnt/stall_cnt).
// Ports:
//   clk, rst_n         : clock, async active-low reset
//   run                : keep issuing instructions (sampled at boundaries)
//   imem_ack, dmem_ack : memory handshake acks
//   reg_Write, mux_D, branch_Select, polarity_Select, mem_Write : decoder
//   zero_flag          : ALU zero, valid in EXEC
//   imem_req, ir_load  : fetch request / IR latch strobe
//   dmem_req, dmem_we  : data request / write strobe
//   rf_we              : register-file write enable
//   pc_en, pc_src      : PC update strobe and source select
//   busy, fault        : activity / sticky memory-timeout fault
//   state_o            : current state encoding
//   retired_cnt, stall_cnt (feature only): performance counters
module mips_seq_ctrl
  import mips_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
`ifdef MIPS_SEQ_PERF_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  input  logic       reg_Write,
  input  logic [1:0] mux_D,
  input  logic [1:0] branch_Select,
  input  logic       polarity_Select,
  input  logic       mem_Write,
  input  logic       zero_flag,
  output logic       imem_req,
  output logic       ir_load,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       rf_we,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       busy,
  output logic       fault,
  output logic [2:0] state_o
`ifdef MIPS_SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  seq_state_e state_r;
  seq_state_e fin_state_s;
  moore_t     mo_r;
  logic [1:0] psrc_r;
  logic [1:0] psrc_s;
  logic       goes_mem_s;
  logic       load_s;
  logic       in_wait_s;
  logic       wait_clear_s;
  logic       ack_s;
  logic       expired_s;
  logic       exec_final_s;
  logic       mem_final_s;

  assign psrc_s       = branch_psrc(branch_Select, zero_flag, polarity_Select);
  assign load_s       = is_load(mux_D);
  assign goes_mem_s   = mem_Write | load_s;
  assign fin_state_s  = run ? S_FETCH : S_IDLE;
  assign in_wait_s    = mo_r.imem_req | mo_r.dmem_req;
  assign wait_clear_s = ~in_wait_s;
  assign ack_s        = (mo_r.imem_req & imem_ack) | (mo_r.dmem_req & dmem_ack);

  // Instruction-ending cycles that are not WB: PC must update in that
  // same cycle, so these are decoded from live inputs.
  assign exec_final_s = (state_r == S_EXEC) & ~goes_mem_s & ~reg_Write;
  assign mem_final_s  = mo_r.dmem_req & dmem_ack & ~load_s;

  seq_timeout_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wait_clear_s),
    .tick    (in_wait_s),
    .ack     (ack_s),
    .expired (expired_s)
  );

  // Sequencer FSM: state, registered per-state outputs and the PC-source latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      mo_r    <= '0;
      psrc_r  <= PC_SRC_SEQ;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (run) begin
            state_r <= S_FETCH;
            mo_r    <= moore_of(S_FETCH, mem_Write, reg_Write);
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            state_r <= S_DECODE;
            mo_r    <= moore_of(S_DECODE, mem_Write, reg_Write);
          end else if (expired_s) begin
            state_r <= S_FAULT;
            mo_r    <= moore_of(S_FAULT, mem_Write, reg_Write);
          end
        end
        S_DECODE: begin
          state_r <= S_EXEC;
          mo_r    <= moore_of(S_EXEC, mem_Write, reg_Write);
        end
        S_EXEC: begin
          psrc_r <= psrc_s;
          if (goes_mem_s) begin
            state_r <= S_MEM;
            mo_r    <= moore_of(S_MEM, mem_Write, reg_Write);
          end else if (reg_Write) begin
            state_r <= S_WB;
            mo_r    <= moore_of(S_WB, mem_Write, reg_Write);
          end else begin
            state_r <= fin_state_s;
            mo_r    <= moore_of(fin_state_s, mem_Write, reg_Write);
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            if (load_s) begin
              state_r <= S_WB;
              mo_r    <= moore_of(S_WB, mem_Write, reg_Write);
            end else begin
              state_r <= fin_state_s;
              mo_r    <= moore_of(fin_state_s, mem_Write, reg_Write);
            end
          end else if (expired_s) begin
            state_r <= S_FAULT;
            mo_r    <= moore_of(S_FAULT, mem_Write, reg_Write);
          end
        end
        S_WB: begin
          state_r <= fin_state_s;
          mo_r    <= moore_of(fin_state_s, mem_Write, reg_Write);
        end
        S_FAULT: begin
          state_r <= S_FAULT;
          mo_r    <= moore_of(S_FAULT, mem_Write, reg_Write);
        end
        default: begin
          // Unused encoding: treat as a fault rather than guess a recovery.
          state_r <= S_FAULT;
          mo_r    <= moore_of(S_FAULT, mem_Write, reg_Write);
        end
      endcase
    end
  end

  // PC strobe and source: WB and MEM-final use the latch, EXEC-final the live value.
  always_comb begin
    pc_en = mo_r.pc_en_wb | exec_final_s | mem_final_s;
    if (mo_r.pc_en_wb || mem_final_s) begin
      pc_src = psrc_r;
    end else if (exec_final_s) begin
      pc_src = psrc_s;
    end else begin
      pc_src = PC_SRC_SEQ;
    end
  end

  assign imem_req = mo_r.imem_req;
  assign ir_load  = mo_r.imem_req & imem_ack;
  assign dmem_req = mo_r.dmem_req;
  assign dmem_we  = mo_r.dmem_we;
  assign rf_we    = mo_r.rf_we;
  assign busy     = mo_r.busy;
  assign fault    = mo_r.fault;
  assign state_o  = state_r;

`ifdef MIPS_SEQ_PERF_CNT_EN
  // Retired instructions and un-acked memory wait cycles; both simply wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (pc_en) begin
        retired_cnt <= retired_cnt + CNT_W'(1);
      end
      if (in_wait_s && !ack_s) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mips_seq_ctrl.sv
// tb_mips_seq_ctrl: randomized instruction stream against a schedule model.
// For each instruction the bench derives, from the sequencing rules, the full
// list of per-cycle expected outputs and queues it; one compare process pops
// and checks one entry on every falling edge.
module tb_mips_seq_ctrl;

  localparam int MEM_TIMEOUT = 16;

  typedef struct packed {
    logic       imem_req;
    logic       ir_load;
    logic       dmem_req;
    logic       dmem_we;
    logic       rf_we;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       busy;
    logic       fault;
    logic [2:0] state;
  } exp_t;

  typedef struct packed {
    logic       rw;
    logic [1:0] md;
    logic [1:0] bs;
    logic       pol;
    logic       mw;
  } dec_t;

  logic clk = 1'b0;
  logic rst_n, run, imem_ack, dmem_ack, reg_Write, polarity_Select, mem_Write, zero_flag;
  logic [1:0] mux_D, branch_Select;
  logic imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_en, busy, fault;
  logic [1:0] pc_src;
  logic [2:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  mips_seq_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .reg_Write(reg_Write), .mux_D(mux_D), .branch_Select(branch_Select),
    .polarity_Select(polarity_Select), .mem_Write(mem_Write), .zero_flag(zero_flag),
    .imem_req(imem_req), .ir_load(ir_load), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .rf_we(rf_we), .pc_en(pc_en), .pc_src(pc_src), .busy(busy), .fault(fault),
    .state_o(state_o)
  );

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  function automatic dec_t rdec();
    logic [6:0] r;
    r = 7'($urandom);
    return r;
  endfunction

  function automatic exp_t mk(logic imr, logic irl, logic dr, logic dwe, logic rfw,
                              logic pce, logic [1:0] ps, logic bsy, logic flt, logic [2:0] st);
    exp_t e;
    e = {imr, irl, dr, dwe, rfw, pce, ps, bsy, flt, st};
    return e;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Single compare process: one expected entry per queued cycle.
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_en, pc_src, busy, fault, state_o};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t got=%b expected=%b (imreq,irld,dreq,dwe,rfwe,pcen,pcsrc[2],busy,flt,st[3])",
                 $time, a, e);
      end
    end
  end

  // One clock cycle: drive inputs just after the rising edge, queue expectation.
  task automatic step(input exp_t e, input logic ia, input logic da, input logic rn,
                      input logic zf, input dec_t d);
    @(posedge clk);
    #1;
    imem_ack = ia;
    dmem_ack = da;
    run      = rn;
    zero_flag = zf;
    {reg_Write, mux_D, branch_Select, polarity_Select, mem_Write} = d;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0),
           rbit(), rbit(), (i == n - 1), rbit(), rdec());
    end
  endtask

  // Schedule one instruction. cut >= 0 asserts rst_n in that MEM wait cycle.
  task automatic run_instr(input dec_t d, input int fw, input int dw, input logic zf,
                           input logic run_after, input int cut, output int ncyc);
    logic taken, to_mem, load, fin;
    logic [1:0] psrc;
    ncyc   = 0;
    taken  = (d.bs == 2'd1) ? (zf ^ d.pol) : (d.bs != 2'd0);
    psrc   = taken ? d.bs : 2'd0;
    load   = (d.md == 2'd1);
    to_mem = d.mw || load;
    // FETCH: decoder fields are not meaningful yet, so feed garbage
    for (int i = 0; i <= fw; i++) begin
      step(mk(1'b1, (i == fw), 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 3'd1),
           (i == fw), rbit(), rbit(), rbit(), rdec());
      ncyc++;
    end
    step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 3'd2),
         rbit(), rbit(), rbit(), rbit(), d);
    ncyc++;
    fin = !to_mem && !d.rw;
    step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fin, fin ? psrc : 2'd0, 1'b1, 1'b0, 3'd3),
         rbit(), rbit(), fin ? run_after : rbit(), zf, d);
    ncyc++;
    if (to_mem) begin
      for (int i = 0; i <= dw; i++) begin
        if (i == cut) begin
          @(posedge clk);
          #1;
          dmem_ack = 1'b0;
          run = 1'b0;
          #1;
          chk("dmem_req_before_rst", 8'(dmem_req), 8'd1);
          rst_n = 1'b0;
          #1;
          chk("dmem_req_in_rst", 8'(dmem_req), 8'd0);
          chk("state_in_rst", 8'(state_o), 8'd0);
          return;
        end
        fin = (i == dw) && !load;
        step(mk(1'b0, 1'b0, 1'b1, d.mw, 1'b0, fin, fin ? psrc : 2'd0, 1'b1, 1'b0, 3'd4),
             rbit(), (i == dw), fin ? run_after : rbit(), rbit(), d);
        ncyc++;
      end
    end
    if (!fin) begin
      step(mk(1'b0, 1'b0, 1'b0, 1'b0, d.rw, 1'b1, psrc, 1'b1, 1'b0, 3'd5),
           rbit(), rbit(), run_after, rbit(), d);
      ncyc++;
    end
  endtask

  function automatic int rwait();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 9) return MEM_TIMEOUT - 1;
    if (r == 8) return MEM_TIMEOUT - 2;
    return r % 4;
  endfunction

  initial begin
    int   n;
    dec_t d;
    logic ra;
    rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; zero_flag = 1'b0;
    {reg_Write, mux_D, branch_Select, polarity_Select, mem_Write} = 7'd0;
    #12;
    chk("reset_outputs",
        8'({imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_en, pc_src}), 8'd0);
    chk("reset_state", 8'({busy, fault, state_o}), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // ALU op: F D E WB
    run_instr('{rw:1'b1, md:2'd0, bs:2'd0, pol:1'b0, mw:1'b0}, 0, 0, 1'b0, 1'b1, -1, n);
    chk("lat_alu", 8'(n), 8'd4);
    // Load with 3 wait cycles: F D E M M M M WB
    run_instr('{rw:1'b1, md:2'd1, bs:2'd0, pol:1'b0, mw:1'b0}, 0, 3, 1'b0, 1'b1, -1, n);
    chk("lat_load_w3", 8'(n), 8'd8);
    // Store: F D E M(final)
    run_instr('{rw:1'b0, md:2'd0, bs:2'd0, pol:1'b0, mw:1'b1}, 0, 0, 1'b0, 1'b1, -1, n);
    chk("lat_store", 8'(n), 8'd4);
    // Conditional branch, polarity 0, zero 1: taken
    run_instr('{rw:1'b0, md:2'd0, bs:2'd1, pol:1'b0, mw:1'b0}, 0, 0, 1'b1, 1'b1, -1, n);
    @(negedge clk); #1;
    chk("br_pol0_pcsrc", 8'({pc_en, pc_src}), 8'b101);
    chk("lat_br_pol0", 8'(n), 8'd3);
    // Conditional branch, polarity 1, zero 1: not taken
    run_instr('{rw:1'b0, md:2'd0, bs:2'd1, pol:1'b1, mw:1'b0}, 0, 0, 1'b1, 1'b1, -1, n);
    @(negedge clk); #1;
    chk("br_pol1_pcsrc", 8'({pc_en, pc_src}), 8'b100);
    chk("lat_br_pol1", 8'(n), 8'd3);
    // Jump-and-link, run dropped: WB then IDLE
    run_instr('{rw:1'b1, md:2'd0, bs:2'd3, pol:1'b0, mw:1'b0}, 0, 0, 1'b0, 1'b0, -1, n);
    @(negedge clk); #1;
    chk("jal_wb", 8'({rf_we, pc_en, pc_src}), 8'b1111);
    chk("lat_jal", 8'(n), 8'd4);
    idle(2);
    // Ack on the last permitted wait cycle in both FETCH and MEM
    run_instr('{rw:1'b0, md:2'd0, bs:2'd0, pol:1'b0, mw:1'b1}, MEM_TIMEOUT - 1,
              MEM_TIMEOUT - 1, 1'b0, 1'b1, -1, n);
    chk("lat_store_limit", 8'(n), 8'd34);

    // Random stream
    for (int k = 0; k < 250; k++) begin
      d  = rdec();
      ra = ($urandom_range(0, 4) != 0);
      run_instr(d, rwait(), rwait(), rbit(), ra, -1, n);
      if (!ra) idle(int'($urandom_range(1, 3)));
    end

    // Reset in the middle of a load's MEM wait
    run_instr('{rw:1'b1, md:2'd1, bs:2'd0, pol:1'b0, mw:1'b0}, 1, 10, 1'b0, 1'b1, 4, n);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Fetch timeout: 16 un-acked FETCH cycles, then sticky FAULT
    run_instr('{rw:1'b1, md:2'd0, bs:2'd0, pol:1'b0, mw:1'b0}, 0, 0, 1'b0, 1'b1, -1, n);
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      step(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 3'd1),
           1'b0, rbit(), rbit(), rbit(), rdec());
    end
    for (int i = 0; i < 4; i++) begin
      step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 3'd7),
           rbit(), rbit(), 1'b1, rbit(), rdec());
    end
    @(negedge clk); #1;
    chk("fault_sticky", 8'({fault, imem_req, busy, state_o}), 8'b100111);
    rst_n = 1'b0;
    run = 1'b0;
    #1;
    chk("fault_cleared", 8'({fault, busy, state_o}), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    run_instr('{rw:1'b1, md:2'd2, bs:2'd2, pol:1'b0, mw:1'b0}, 2, 0, 1'b0, 1'b0, -1, n);
    chk("lat_after_fault", 8'(n), 8'd6);
    idle(1);

    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
